// File: rtl/tach_signal_gen_pkg.sv
// Shared constants, types and helpers for the tachometer signal synthesizer.
package tach_signal_gen_pkg;

  // Emulated ADC sample width.
  localparam int unsigned ADC_WIDTH = 12;

  // RPM setpoint width; wide enough for setpoints up to 1_048_575 RPM.
  localparam int unsigned RPM_WIDTH = 20;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } div_state_e;

  // K = 60 * CLK_HZ / (SAMPLE_DIV * PULSES_PER_REV): samples per minute per pulse.
  function automatic logic [63:0] calc_k(input int unsigned clk_hz,
                                         input int unsigned sample_div,
                                         input int unsigned ppr);
    return (64'd60 * 64'(clk_hz)) / (64'(sample_div) * 64'(ppr));
  endfunction

endpackage

// File: rtl/tach_signal_gen_div.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
module rpm_period_div
  import tach_signal_gen_pkg::*;
#(
  parameter int unsigned K_WIDTH = 32,
  parameter int unsigned D_WIDTH = RPM_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [K_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               done,
  output logic [K_WIDTH-1:0] quotient
);

  localparam int unsigned CNT_W = (K_WIDTH > 2) ? $clog2(K_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_WIDTH - 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [D_WIDTH-1:0] rem_q;
  logic [D_WIDTH-1:0] dvs_q;
  logic [K_WIDTH-1:0] quo_q;
  logic               done_q;

  logic [D_WIDTH:0]   trial;
  logic [D_WIDTH:0]   diff;
  logic               fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial = {rem_q, quo_q[K_WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    fits  = (trial >= {1'b0, dvs_q});
  end

  // Divider FSM: a start always (re)loads operands, discarding any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= S_DIV;
        cnt_q   <= '0;
        rem_q   <= '0;
        dvs_q   <= divisor;
        quo_q   <= dividend;
      end else begin
        case (state_q)
          S_DIV: begin
            rem_q <= fits ? diff[D_WIDTH-1:0] : trial[D_WIDTH-1:0];
            quo_q <= {quo_q[K_WIDTH-2:0], fits};
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/tach_signal_gen.sv
// Tachometer signal synthesizer: RPM setpoint in, square-wave ADC sample stream out.
module tach_signal_gen
  import tach_signal_gen_pkg::*;
#(
  parameter int unsigned          CLK_HZ         = 1000000,
  parameter int unsigned          SAMPLE_DIV     = 64,
  parameter int unsigned          PULSES_PER_REV = 1,
  parameter logic [ADC_WIDTH-1:0] ADC_HIGH       = 12'd4095,
  parameter logic [ADC_WIDTH-1:0] ADC_LOW        = 12'd0,
  parameter int unsigned          K_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RPM_WIDTH-1:0] rpm_set,
  input  logic                 rpm_set_change,
  output logic [ADC_WIDTH-1:0] adc_value,
  output logic                 adc_value_change,
  output logic                 pulse_ref,
  output logic                 busy
);

  localparam logic [K_WIDTH-1:0] K_VAL      = K_WIDTH'(calc_k(CLK_HZ, SAMPLE_DIV, PULSES_PER_REV));
  localparam logic [K_WIDTH-1:0] PERIOD_MIN = K_WIDTH'(2);
  localparam int unsigned        TMR_W      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(SAMPLE_DIV - 1);

  logic                 chg_sync_q, chg_sync_d;
  logic                 chg_prev_q, chg_prev_d;
  logic                 rpm_zero_q, rpm_zero_d;
  logic                 busy_q, busy_d;
  logic [K_WIDTH-1:0]   pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [K_WIDTH-1:0]   period_q, period_d;
  logic [K_WIDTH-1:0]   phase_q, phase_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [ADC_WIDTH-1:0] adc_q, adc_d;
  logic                 adc_chg_q, adc_chg_d;
  logic                 pulse_q, pulse_d;

  logic                 detect;
  logic                 tick;
  logic                 commit;
  logic                 div_done;
  logic [K_WIDTH-1:0]   div_quot;
  logic [K_WIDTH-1:0]   period_new;
  logic [K_WIDTH-1:0]   p_eff;
  logic [K_WIDTH-1:0]   ph_eff;
  logic [K_WIDTH-1:0]   ph_inc;

  rpm_period_div #(
    .K_WIDTH (K_WIDTH),
    .D_WIDTH (RPM_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (detect),
    .dividend (K_VAL),
    .divisor  (rpm_set),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Setpoint detect, result staging, commit and sample generation.
  // A commit and a sample on the same clock see the new period at phase 0,
  // so p_eff/ph_eff feed both the waveform and the next-state registers.
  always_comb begin
    chg_sync_d   = rpm_set_change;
    chg_prev_d   = chg_sync_q;
    rpm_zero_d   = rpm_zero_q;
    busy_d       = busy_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    adc_d        = adc_q;
    adc_chg_d    = adc_chg_q;
    pulse_d      = 1'b0;

    detect = chg_sync_q ^ chg_prev_q;
    tick   = (tmr_q == TMR_LAST);
    tmr_d  = tick ? '0 : tmr_q + TMR_W'(1);

    if (rpm_zero_q)                 period_new = '0;
    else if (div_quot < PERIOD_MIN) period_new = PERIOD_MIN;
    else                            period_new = div_quot;

    commit = pend_valid_q && !detect && ((period_q == '0) || (phase_q == '0));
    p_eff  = commit ? pend_q : period_q;
    ph_eff = commit ? '0 : phase_q;
    ph_inc = ph_eff + K_WIDTH'(1);

    if (commit) begin
      pend_valid_d = 1'b0;
      busy_d       = 1'b0;
    end
    if (div_done) begin
      pend_d       = period_new;
      pend_valid_d = 1'b1;
    end
    if (detect) begin
      rpm_zero_d   = (rpm_set == '0);
      busy_d       = 1'b1;
      pend_valid_d = 1'b0;
    end

    period_d = p_eff;
    phase_d  = ph_eff;
    if (tick) begin
      adc_chg_d = ~adc_chg_q;
      if (p_eff == '0) begin
        adc_d   = ADC_LOW;
        phase_d = '0;
      end else begin
        adc_d   = (ph_eff < (p_eff >> 1)) ? ADC_HIGH : ADC_LOW;
        pulse_d = (ph_eff == '0);
        phase_d = (ph_inc == p_eff) ? '0 : ph_inc;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_sync_q   <= 1'b0;
      chg_prev_q   <= 1'b0;
      rpm_zero_q   <= 1'b1;
      busy_q       <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      period_q     <= '0;
      phase_q      <= '0;
      tmr_q        <= '0;
      adc_q        <= ADC_LOW;
      adc_chg_q    <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      chg_sync_q   <= chg_sync_d;
      chg_prev_q   <= chg_prev_d;
      rpm_zero_q   <= rpm_zero_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      period_q     <= period_d;
      phase_q      <= phase_d;
      tmr_q        <= tmr_d;
      adc_q        <= adc_d;
      adc_chg_q    <= adc_chg_d;
      pulse_q      <= pulse_d;
    end
  end

  assign adc_value        = adc_q;
  assign adc_value_change = adc_chg_q;
  assign pulse_ref        = pulse_q;
  assign busy             = busy_q;

endmodule

// File: doc/tach_signal_gen.md
# tach_signal_gen

Tachometer signal synthesizer: converts an RPM setpoint into a stream of emulated 12-bit ADC samples, a square wave at the matching pulse rate, delivered with the same value-plus-toggle-strobe interface the `threshold` front end consumes. It is the transmit end of the ADC sample path. It drives `threshold` → `rpm` in closed-loop benches and on hardware bring-up boards without a real sensor. A reference pulse output lets checkers compare measured period against the ideal.

## Interface
- `CLK_HZ`, 1000000: clock frequency in Hz.
- `SAMPLE_DIV`, 64: clocks per emitted ADC sample (≥2).
- `PULSES_PER_REV`, 1: sensor pulses per revolution (≥1).
- `ADC_HIGH`, 4095: sample value during high phase.
- `ADC_LOW`, 0: sample value during low phase.
- `K_WIDTH`, 32: dividend/quotient width; K = 60·CLK_HZ/(SAMPLE_DIV·PULSES_PER_REV) must fit.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rpm_set`  in  `RPM_WIDTH`  requested RPM; sampled when `rpm_set_change` toggles.
- `rpm_set_change`  in  1  toggle strobe; any level change means a new `rpm_set`.
- `adc_value`  out  12  emulated ADC sample.
- `adc_value_change`  out  1  toggles once per new `adc_value`.
- `pulse_ref`  out  1  one-clock pulse coincident with the sample that starts each period.
- `busy`  out  1  divider running or result pending commit.

## Operation
- Setpoint path: `rpm_set_change` registered; new setpoint when it differs from previous registered value. On detect: latch `rpm_set`, start divider, `busy`=1.
- Divider FSM: IDLE → DIV (K_WIDTH iterations, restoring, 1 bit/clock) → DONE (result into `pending_period`, `pending_valid`=1) → IDLE. New toggle in DIV or DONE restarts DIV with newest setpoint; old result discarded.
- Period P = K / rpm (truncating). rpm=0 → P=0 → output held at `ADC_LOW`, no `pulse_ref`. Nonzero rpm with quotient <2 → P clamped to 2.
- Sample timer: free-running mod-SAMPLE_DIV counter; at terminal count emit sample: update `adc_value`, toggle `adc_value_change`.
- Waveform: phase counter 0..P−1, advanced per sample. Phase < P>>1 → `ADC_HIGH`, else `ADC_LOW`.
- Commit: `pending_period` becomes active only at a period boundary (phase wraps to 0) or immediately when active P is 0. `busy` falls on commit. Output is phase-continuous; no partial periods.
- `pulse_ref` asserted for the clock on which a phase-0 sample is emitted with P≠0.

## Timing
- Reset values: `adc_value`=ADC_LOW, `adc_value_change`=0, `pulse_ref`=0, `busy`=0, active P=0, counters 0, FSM IDLE.
- First sample strobe SAMPLE_DIV clocks after `rst_n` deasserts. Strobe spacing is exactly SAMPLE_DIV clocks always.
- Toggle to `busy`=1: 2 clocks. Detect to `pending_valid`: K_WIDTH+2 clocks.
- Simultaneous commit and sample: sample uses new P, phase 0.
- Reset mid-divide or mid-period: everything returns to reset values; pending result lost.
- Phase counter and P are K_WIDTH bits; phase compare is unsigned.

## Structure
- `RPM_WIDTH` comes from `rpm_config.v`. ADC width 12 and K computation macros go in `adc_config.v`/`rpm_config.v` as shared constants, not local literals.
- One sub-module: `rpm_period_div`, sequential unsigned divider (start/done, K_WIDTH dividend, RPM_WIDTH divisor). Waveform/timer logic stays in the top.

## Test plan
With defaults (K = 937500):
- Reset, no setpoint → strobe every 64 clocks, `adc_value`=0, no `pulse_ref`, `busy`=0.
- Set rpm=9375 → `busy` for 34 clocks, then P=100: 50 samples of 4095, 50 of 0, `pulse_ref` every 6400 clocks. Closed loop through `threshold`/`rpm` reports period consistent with 6400 clocks.
- Change 9375→18750 mid-period → current 100-sample period completes, then P=50 (25/25); no short period.
- Set rpm=1000000 → quotient 0 clamped to 2: alternating 4095/0 each sample.
- Two toggles 10 clocks apart (rpm 9375, then 4687) → only P=200 is committed; `busy` stays high through both.
- Assert `rst_n`=0 during DIV and mid high phase → outputs at reset values on the same clock; recovery timing as in scenario 1.
